seg7_scan_capture: RTL and testbench
====================================

Name: seg7_scan_capture

Overview:
- Receiving end of the multiplexed 4-digit seven-segment interface (anode/segment) driven by the display scanner.
- Samples the scanned anode/segment lines, waits for them to settle, and decodes each digit's pattern back to a hex nibble plus decimal point.
- Holds a 4-digit snapshot and flags completed scan frames.
- Used as an on-chip loop-back checker and as the display monitor in board-level benches.

Parameters:
- SETTLE_CYCLES, 4: consecutive clk cycles that the synchronised anode+segment must be unchanged before a capture. Legal range 1..255.
- ANODE_ACTIVE_LOW, 1: 1 means a digit is selected when its anode bit is 0.
- SEG_ACTIVE_LOW, 1: 1 means a segment is lit when its bit is 0. Applies to dp as well.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-high reset.
- anode, input, 4: digit select from the scanner; bit i selects digit i.
- segment, input, 8: segment lines; [0]=a … [6]=g, [7]=dp.
- digits, output, 16: captured nibbles; digit i is at [4i+3:4i].
- dp, output, 4: captured decimal point per digit, active-high.
- digit_valid, output, 4: bit i set once digit i has been captured with a legal pattern.
- invalid, output, 4: sticky; bit i set when digit i showed an undecodable pattern.
- frame_done, output, 1: one-cycle pulse when all four digits have been captured since the previous pulse.
- frame_count, output, 16: number of frame_done pulses; wraps 0xFFFF→0.

Behaviour:
- Clock and reset: one clock domain. rst is asynchronous and active-high.
- Reset values: all outputs 0, FSM in IDLE, stable counter 0, seen mask 0.
- Input synchronisation: anode and segment each pass through a 2-flop synchronizer. They are then normalised to active-high using the parameters.
- Stability: the stable counter resets to 0 whenever the synchronised {anode,segment} differs from its value on the previous cycle. Otherwise it increments, saturating at SETTLE_CYCLES.
- FSM:
  - IDLE: normalised anode is not one-hot (0 or ≥2 bits set). No capture. Go to SETTLE when anode becomes one-hot.
  - SETTLE: one-hot anode, waiting. When the counter reaches SETTLE_CYCLES, perform a capture on that same edge and go to HOLD.
  - HOLD: wait for any change of {anode,segment}.
    - New anode is one-hot → SETTLE.
    - New anode is not one-hot → IDLE.
    - Segment-only change with the same anode → SETTLE; this is a re-capture of the same digit.
- Latency: with inputs stable from the change, digits/dp/flags update exactly SETTLE_CYCLES+2 clk edges after the input change (2 synchronizer edges plus SETTLE_CYCLES).
- Capture of digit i:
  - Decode the 7-bit pattern gfedcba. Legal patterns:
    - 0–7: 3F, 06, 5B, 4F, 66, 6D, 7D, 07
    - 8–F: 7F, 6F, 77, 7C, 39, 5E, 79, 71
  - Legal pattern: write the nibble to digits[i], write dp[i], set digit_valid[i], set seen[i].
  - Any other pattern, including blank 00: set invalid[i]; leave digits[i], dp[i] and digit_valid[i] unchanged; still set seen[i].
- Frame completion:
  - When the seen mask becomes 4'hF, pulse frame_done on the following edge, clear seen to 0 on that same edge, and increment frame_count.
  - A re-capture of an already-seen digit neither double-counts nor pulses frame_done.
- Simultaneous events: a capture on the same edge as seen clear is ORed into the freshly cleared mask and is not lost.
- Sticky flags: invalid and digit_valid clear only on rst.
- Reset mid-operation: immediate return to the reset state. A partially collected frame is discarded.

Decomposition:
- Shared package / include seg7_defs: FSM state encodings (IDLE, SETTLE, HOLD), the 16-entry pattern constant table, and the segment bit-index constants (SEG_A..SEG_G, SEG_DP).
- Sub-module seg7_pattern_decode: combinational; 7-bit pattern in, 4-bit nibble plus legal flag out. Shared with future display-side users.
- All sequential logic stays in seg7_scan_capture.

Test Plan:
- Reset: assert rst mid-frame after digits 0–1 are captured → all outputs 0 immediately. The next full scan gives frame_done after exactly 4 digits.
- Active-low scan, SETTLE_CYCLES=4, 200 cycles per digit: anode E,D,B,7 with segment {dp off} patterns for 1,2,3,4 (~06, ~5B, ~4F, ~66) → digits=16'h4321, dp=0, digit_valid=F, one frame_done, frame_count=1.
- Latency: a single digit change held stable → digits update exactly 6 edges after the input edge. A 3-cycle glitch pulse on segment within HOLD produces no change unless it is held ≥4 cycles after synchronisation.
- Ghosting: anode=4'hC (two digits active) for 100 cycles → no capture and no frame_done. Returning to one-hot resumes capture normally.
- Illegal pattern: digit 2 shows ~7'h49 → invalid=4'b0100, digits[11:8] retains its previous value, and the frame still completes when the other digits are seen.
- Wrap and re-capture: preload 65535 frames (or force the counter) → the next frame gives frame_count=0. Changing digit 0's segment twice within one frame → one frame_done only.

Source files
------------

// File: rtl/seg7_defs.sv
// seg7_defs: shared FSM states, segment bit indices and hex pattern table for the seven-segment capture path.
package seg7_defs;
  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, HOLD = 2'd2} state_e;
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;
  // gfedcba patterns indexed by hex digit value
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  function automatic logic is_onehot(input logic [3:0] v);
    return v != 4'h0 && (v & (v - 4'h1)) == 4'h0;
  endfunction
endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: maps an active-high gfedcba pattern to its hex nibble and flags unknown patterns.
module seg7_pattern_decode
  import seg7_defs::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       legal
);
  always_comb begin
    nibble = 4'h0;
    legal  = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (pattern == SEG_TABLE[k]) begin
        nibble = 4'(k);
        legal  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: samples a multiplexed 4-digit anode/segment bus, waits for it to settle
// and rebuilds the displayed hex digits, decimal points and frame statistics.
module seg7_scan_capture
  import seg7_defs::*;
#(
  parameter int unsigned SETTLE_CYCLES    = 4,
  parameter bit          ANODE_ACTIVE_LOW = 1'b1,
  parameter bit          SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  anode,
  input  logic [7:0]  segment,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic [3:0]  digit_valid,
  output logic [3:0]  invalid,
  output logic        frame_done,
  output logic [15:0] frame_count
);
  localparam logic [7:0] SETTLE_N = 8'(SETTLE_CYCLES);
  logic [3:0]  an_s1_q, an_s2_q;
  logic [7:0]  sg_s1_q, sg_s2_q;
  logic [7:0]  cnt_q, cnt_d;
  state_e      state_q, state_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  dp_q, dp_d, valid_q, valid_d, invalid_q, invalid_d, seen_q, seen_d;
  logic        frame_done_q, frame_done_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic [3:0]  an_n, an1_n, cap_mask, nib;
  logic [7:0]  sg_n;
  logic [6:0]  pattern;
  logic        chg, cap, legal;
  assign an_n    = an_s2_q ^ {4{ANODE_ACTIVE_LOW}};
  assign an1_n   = an_s1_q ^ {4{ANODE_ACTIVE_LOW}};
  assign sg_n    = sg_s2_q ^ {8{SEG_ACTIVE_LOW}};
  assign pattern = {sg_n[SEG_G], sg_n[SEG_F], sg_n[SEG_E], sg_n[SEG_D],
                    sg_n[SEG_C], sg_n[SEG_B], sg_n[SEG_A]};
  // The synchronised value changes on this edge when the first stage disagrees with the second
  assign chg = {an_s1_q, sg_s1_q} != {an_s2_q, sg_s2_q};
  seg7_pattern_decode u_decode (
    .pattern(pattern),
    .nibble (nib),
    .legal  (legal)
  );
  always_comb begin
    cnt_d    = chg ? 8'd0 : (cnt_q == SETTLE_N ? cnt_q : cnt_q + 8'd1);
    cap      = state_q == SETTLE && !chg && cnt_d == SETTLE_N;
    cap_mask = cap ? an_n : 4'h0;
    state_d  = chg ? (is_onehot(an1_n) ? SETTLE : IDLE) :
               cap ? HOLD :
               (state_q == IDLE && is_onehot(an_n)) ? SETTLE : state_q;
    digits_d = digits_q;
    dp_d     = dp_q;
    for (int i = 0; i < 4; i++) begin
      if (cap_mask[i] && legal) begin
        digits_d[4*i +: 4] = nib;
        dp_d[i]            = sg_n[SEG_DP];
      end
    end
    valid_d       = valid_q | (legal ? cap_mask : 4'h0);
    invalid_d     = invalid_q | (legal ? 4'h0 : cap_mask);
    frame_done_d  = seen_q == 4'hF;
    // A capture landing on the clearing edge opens the next frame
    seen_d        = (frame_done_d ? 4'h0 : seen_q) | cap_mask;
    frame_count_d = frame_count_q + 16'(frame_done_d);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_s1_q       <= 4'h0;
      an_s2_q       <= 4'h0;
      sg_s1_q       <= 8'h0;
      sg_s2_q       <= 8'h0;
      cnt_q         <= 8'd0;
      state_q       <= IDLE;
      digits_q      <= 16'h0;
      dp_q          <= 4'h0;
      valid_q       <= 4'h0;
      invalid_q     <= 4'h0;
      seen_q        <= 4'h0;
      frame_done_q  <= 1'b0;
      frame_count_q <= 16'h0;
    end else begin
      an_s1_q       <= anode;
      an_s2_q       <= an_s1_q;
      sg_s1_q       <= segment;
      sg_s2_q       <= sg_s1_q;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      digits_q      <= digits_d;
      dp_q          <= dp_d;
      valid_q       <= valid_d;
      invalid_q     <= invalid_d;
      seen_q        <= seen_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end
  assign digits      = digits_q;
  assign dp          = dp_q;
  assign digit_valid = valid_q;
  assign invalid     = invalid_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture: random and directed scans against a digit-level reference model;
// frame snapshots are queued at stimulus time and checked whenever frame_done pulses.
module tb_seg7_scan_capture;
  localparam int SETTLE = 4;
  localparam logic [6:0] PAT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  dp;
    logic [3:0]  v;
    logic [3:0]  inv;
    logic [15:0] c;
  } snap_t;
  logic        clk = 1'b0, rst = 1'b1;
  logic [3:0]  anode = 4'hF;
  logic [7:0]  segment = 8'hFF;
  logic [15:0] digits, frame_count;
  logic [3:0]  dp, digit_valid, invalid;
  logic        frame_done;
  int tests = 0, fails = 0;
  snap_t sb[$];
  logic [15:0] m_digits, m_cnt;
  logic [3:0]  m_dp, m_val, m_inv, m_seen;
  logic [11:0] m_prev;
  seg7_scan_capture dut (
    .clk(clk), .rst(rst), .anode(anode), .segment(segment), .digits(digits), .dp(dp),
    .digit_valid(digit_valid), .invalid(invalid), .frame_done(frame_done), .frame_count(frame_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic snap_t model_snap();
    return '{d: m_digits, dp: m_dp, v: m_val, inv: m_inv, c: m_cnt};
  endfunction
  task automatic model_reset();
    m_digits = '0; m_dp = '0; m_val = '0; m_inv = '0; m_seen = '0; m_cnt = '0;
    m_prev = {4'hF, 8'hFF};
  endtask
  // A digit is captured when a new one-hot selection is held long enough to settle
  task automatic model_apply(input logic [3:0] an, input logic [7:0] sg, input int cyc);
    logic [3:0] sel;
    int idx, val;
    sel = ~an;
    if ({an, sg} != m_prev && $countones(sel) == 1 && cyc >= SETTLE + 2) begin
      idx = 0;
      val = -1;
      for (int i = 0; i < 4; i++) if (sel[i]) idx = i;
      for (int k = 0; k < 16; k++) if (PAT[k] == ~sg[6:0]) val = k;
      if (val >= 0) begin
        m_digits[4*idx +: 4] = 4'(val);
        m_dp[idx] = ~sg[7];
        m_val[idx] = 1'b1;
      end else m_inv[idx] = 1'b1;
      m_seen[idx] = 1'b1;
      if (m_seen == 4'hF) begin
        m_seen = 4'h0;
        m_cnt++;
        sb.push_back(model_snap());
      end
    end
    m_prev = {an, sg};
  endtask
  task automatic show(input logic [3:0] an, input logic [7:0] sg, input int cyc);
    anode = an;
    segment = sg;
    model_apply(an, sg, cyc);
    repeat (cyc) @(negedge clk);
  endtask
  function automatic logic [7:0] seg_of(input int v, input bit dpon);
    return ~{dpon, PAT[v]};
  endfunction
  function automatic logic [3:0] an_of(input int i);
    return ~(4'b0001 << i);
  endfunction
  always @(negedge clk) begin
    snap_t e;
    if (!rst && frame_done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL frame_unexpected: got frame_done=1 count=%h expected no pulse", frame_count);
      end else begin
        e = sb.pop_front();
        chk("frame_digits", 64'(digits), 64'(e.d));
        chk("frame_dp", 64'(dp), 64'(e.dp));
        chk("frame_valid", 64'(digit_valid), 64'(e.v));
        chk("frame_invalid", 64'(invalid), 64'(e.inv));
        chk("frame_count", 64'(frame_count), 64'(e.c));
      end
    end
  end
  initial begin
    int lat, v;
    logic [7:0] sg;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_state", 64'({digits, dp, digit_valid, invalid, frame_done, frame_count}), 64'h0);
    rst = 1'b0;
    @(negedge clk);
    // partial frame then asynchronous reset
    show(an_of(0), seg_of(7, 0), 50);
    show(an_of(1), seg_of(8, 1), 50);
    chk("pre_reset_digits", 64'(digits[7:0]), 64'h87);
    #2 rst = 1'b1;
    anode = 4'hF;
    segment = 8'hFF;
    #1 chk("async_reset", 64'({digits, dp, digit_valid, invalid, frame_done, frame_count}), 64'h0);
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // nominal scan of 1,2,3,4
    show(4'hE, 8'hF9, 200);
    show(4'hD, 8'hA4, 200);
    show(4'hB, 8'hB0, 200);
    show(4'h7, 8'h99, 200);
    chk("scan_digits", 64'(digits), 64'h4321);
    chk("scan_dp", 64'(dp), 64'h0);
    chk("scan_valid", 64'(digit_valid), 64'hF);
    chk("scan_count", 64'(frame_count), 64'h1);
    // capture latency
    anode = 4'hE;
    segment = seg_of(5, 0);
    model_apply(4'hE, segment, 200);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1 if (lat == 0 && digits[3:0] == 4'h5) lat = n;
    end
    chk("latency_edges", 64'(lat), 64'(SETTLE + 2));
    repeat (10) @(negedge clk);
    // short segment glitch while holding
    show(4'hE, seg_of(7, 0), 3);
    show(4'hE, seg_of(5, 0), 40);
    chk("glitch_ignored", 64'(digits[3:0]), 64'h5);
    // two anodes active at once
    show(4'hC, seg_of(9, 0), 100);
    chk("ghost_digits", 64'(digits), 64'(m_digits));
    chk("ghost_count", 64'(frame_count), 64'(m_cnt));
    // undecodable pattern on digit 2
    show(4'hB, ~8'h49, 60);
    chk("illegal_invalid", 64'(invalid), 64'h4);
    chk("illegal_retain", 64'(digits[11:8]), 64'h3);
    show(4'hE, seg_of(1, 0), 60);
    show(4'hD, seg_of(2, 0), 60);
    show(4'h7, seg_of(4, 0), 60);
    // counter wrap
    @(negedge clk);
    force dut.frame_count_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count_q;
    for (int i = 0; i < 4; i++) show(an_of(i), seg_of(i + 10, 1), 60);
    chk("wrap_count", 64'(frame_count), 64'h0);
    // re-capture of one digit inside a frame
    show(4'hE, seg_of(6, 0), 60);
    show(4'hE, seg_of(14, 1), 60);
    for (int i = 1; i < 4; i++) show(an_of(i), seg_of(i, 0), 60);
    chk("recapture_count", 64'(frame_count), 64'(m_cnt));
    // randomized scanning
    for (int s = 0; s < 80; s++) begin
      v = $urandom_range(0, 9);
      if (v == 0) show(4'(~$urandom_range(3, 15) | 4'h0), 8'($urandom), $urandom_range(10, 40));
      else if (v == 1) begin
        do sg = 8'($urandom); while (PAT.sum() with (int'(item == ~sg[6:0])) != 0);
        show(an_of($urandom_range(0, 3)), sg, $urandom_range(10, 40));
      end else show(an_of($urandom_range(0, 3)), seg_of($urandom_range(0, 15), 1'($urandom)),
                    $urandom_range(10, 40));
    end
    repeat (20) @(negedge clk);
    chk("final_state", 64'({digits, dp, digit_valid, invalid, frame_count}),
        64'({m_digits, m_dp, m_val, m_inv, m_cnt}));
    chk("scoreboard_empty", 64'(sb.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
